layer2_conv: RTL and testbench

LAYER2_CONV -- requirements
Module: layer2_conv

---
 rtl/layer2_conv.sv | 228 ++++++++++++++++++++++
 tb/tb_layer2_conv.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer2_conv.sv
`default_nettype none
// ============================================================================
// Module   : layer2_conv
// Purpose  : Layer-2 convolution engine. Reads IC pooled 16x16 input maps,
//            applies an OC x IC x 3x3 valid convolution, and emits one
//            saturated 8-bit result per 14x14 output pixel. After the last
//            pixel it requests a 2x2 max-pool/ReLU pass from the result
//            memory and signals done.
// Ports    : clk, rst (async, active-low)
//            start                 - one-cycle run request (accepted in IDLE only)
//            act_addr / act_data   - activation ROM (data one cycle after addr)
//            wt_addr  / wt_data    - weight ROM     (data one cycle after addr)
//            bias_addr/ bias_data  - bias ROM       (data one cycle after addr)
//            store, out_c, w_addr, value, bias - result-memory write port
//            pool / pool_done      - pool request level / completion
//            busy, done            - run status
// Revision : 1.0 - initial release
// ============================================================================
module layer2_conv #(
  parameter int IC    = 8,
  parameter int OC    = 16,
  parameter int SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [11:0]       act_addr,
  input  logic signed [7:0] act_data,
  output logic [10:0]       wt_addr,
  input  logic signed [7:0] wt_data,
  output logic [3:0]        bias_addr,
  input  logic signed [7:0] bias_data,
  output logic              store,
  output logic [3:0]        out_c,
  output logic [7:0]        w_addr,
  output logic signed [7:0] value,
  output logic signed [7:0] bias,
  output logic              pool,
  input  logic              pool_done,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_POOL  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [7:0]  MAC_LAST  = 8'(IC * 9 - 1);
  localparam logic [3:0]  IC_LAST   = 4'(IC - 1);
  localparam logic [3:0]  OC_LAST   = 4'(OC - 1);
  localparam logic [3:0]  DIM_LAST  = 4'd13;
  localparam logic [10:0] OC_STRIDE = 11'(IC * 9);

  logic [2:0]         r_state;
  logic [3:0]         r_oc, r_orow, r_ocol;
  logic [3:0]         r_ic;
  logic [1:0]         r_ky, r_kx;
  logic [7:0]         r_mac_cnt;
  logic               r_addr_on;   // an address pair is on the ROM bus this cycle
  logic               r_prod_vld;  // ROM data for that pair is valid this cycle
  logic signed [23:0] r_acc;

  logic               w_issue;
  logic               w_last_pix;
  logic [3:0]         w_row, w_col;
  logic [11:0]        w_act_addr;
  logic [10:0]        w_wt_addr;
  logic signed [15:0] w_prod;
  logic signed [23:0] w_acc_next;
  logic signed [23:0] w_shifted;
  logic signed [7:0]  w_sat;

  // Addresses are registered, so the pair for MAC cycle j is loaded at the
  // end of the previous cycle: INIT loads pair 0, MAC cycles load the rest.
  assign w_issue    = (r_state == S_INIT) ||
                      ((r_state == S_MAC) && (r_mac_cnt != MAC_LAST));
  assign w_last_pix = (r_oc == OC_LAST) && (r_orow == DIM_LAST) && (r_ocol == DIM_LAST);

  assign w_row      = r_orow + {2'b00, r_ky};
  assign w_col      = r_ocol + {2'b00, r_kx};
  // ic*256 + row*16 + col is a plain field concatenation
  assign w_act_addr = {r_ic, w_row, w_col};
  assign w_wt_addr  = 11'(r_oc) * OC_STRIDE + 11'(r_ic) * 11'd9 +
                      11'(r_ky) * 11'd3 + 11'(r_kx);

  assign w_prod     = act_data * wt_data;
  assign w_acc_next = r_prod_vld ? (r_acc + {{8{w_prod[15]}}, w_prod}) : r_acc;
  assign w_shifted  = w_acc_next >>> SHIFT;

  always_comb begin
    w_sat = w_shifted[7:0];
    if (w_shifted > 24'sd127)
      w_sat = 8'sd127;
    else if (w_shifted < -24'sd128)
      w_sat = -8'sd128;
  end

  // Bias ROM address tracks the channel counter, so it is valid during INIT
  assign bias_addr = r_oc;
  assign store     = (r_state == S_WRITE);
  assign pool      = (r_state == S_POOL);
  assign done      = (r_state == S_FIN);
  assign busy      = (r_state != S_IDLE);

  // Control FSM and pixel counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_oc      <= 4'd0;
      r_orow    <= 4'd0;
      r_ocol    <= 4'd0;
      r_mac_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_INIT;
            r_oc    <= 4'd0;
            r_orow  <= 4'd0;
            r_ocol  <= 4'd0;
          end
        end
        S_INIT: begin
          r_mac_cnt <= 8'd0;
          r_state   <= S_MAC;
        end
        S_MAC: begin
          if (r_mac_cnt == MAC_LAST)
            r_state <= S_DRAIN;
          else
            r_mac_cnt <= r_mac_cnt + 8'd1;
        end
        S_DRAIN: r_state <= S_WRITE;
        S_WRITE: begin
          if (w_last_pix) begin
            r_state <= S_POOL;
            r_oc    <= 4'd0;
            r_orow  <= 4'd0;
            r_ocol  <= 4'd0;
          end else begin
            r_state <= S_INIT;
            if (r_ocol == DIM_LAST) begin
              r_ocol <= 4'd0;
              if (r_orow == DIM_LAST) begin
                r_orow <= 4'd0;
                r_oc   <= r_oc + 4'd1;
              end else begin
                r_orow <= r_orow + 4'd1;
              end
            end else begin
              r_ocol <= r_ocol + 4'd1;
            end
          end
        end
        S_POOL:  if (pool_done) r_state <= S_FIN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MAC datapath: address generation, product pipeline, accumulator, bias
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ic       <= 4'd0;
      r_ky       <= 2'd0;
      r_kx       <= 2'd0;
      act_addr   <= 12'd0;
      wt_addr    <= 11'd0;
      r_addr_on  <= 1'b0;
      r_prod_vld <= 1'b0;
      r_acc      <= 24'sd0;
      bias       <= 8'sd0;
    end else begin
      r_addr_on  <= w_issue;
      r_prod_vld <= r_addr_on;

      if (r_state == S_IDLE) begin
        r_ic <= 4'd0;
        r_ky <= 2'd0;
        r_kx <= 2'd0;
      end else if (w_issue) begin
        act_addr <= w_act_addr;
        wt_addr  <= w_wt_addr;
        // kx innermost, then ky, then ic; the final wrap leaves all at zero
        if (r_kx == 2'd2) begin
          r_kx <= 2'd0;
          if (r_ky == 2'd2) begin
            r_ky <= 2'd0;
            r_ic <= (r_ic == IC_LAST) ? 4'd0 : r_ic + 4'd1;
          end else begin
            r_ky <= r_ky + 2'd1;
          end
        end else begin
          r_kx <= r_kx + 2'd1;
        end
      end

      if (r_state == S_INIT)
        r_acc <= 24'sd0;
      else
        r_acc <= w_acc_next;

      // bias_addr was on the bus during INIT, so its data is valid in MAC 0
      if ((r_state == S_MAC) && (r_mac_cnt == 8'd0))
        bias <= bias_data;
    end
  end

  // Result write port; captured as DRAIN folds in the final product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value  <= 8'sd0;
      out_c  <= 4'd0;
      w_addr <= 8'd0;
    end else if (r_state == S_DRAIN) begin
      value  <= w_sat;
      out_c  <= r_oc;
      w_addr <= 8'(r_orow) * 8'd14 + 8'(r_ocol);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer2_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer2_conv
// Purpose  : Self-checking bench for layer2_conv. Three instances:
//            u_small (IC=1,OC=1,SHIFT=0) constant-one data, pixel cadence,
//            u_sat   (IC=8,OC=1,SHIFT=0) constant-fill saturation table,
//            u_main  (IC=2,OC=4,SHIFT=4) random ROMs vs. a 3-D array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer2_conv;

  localparam int M_IC    = 2;
  localparam int M_OC    = 4;
  localparam int M_SHIFT = 4;
  localparam int M_PIX   = M_OC * 196;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- small instance ----------------
  logic        s_start = 1'b0, s_pool_done = 1'b0;
  logic [11:0] s_act_addr;
  logic [10:0] s_wt_addr;
  logic [3:0]  s_bias_addr, s_out_c;
  logic        s_store, s_pool, s_busy, s_done;
  logic [7:0]  s_w_addr;
  logic signed [7:0] s_value, s_bias;

  layer2_conv #(.IC(1), .OC(1), .SHIFT(0)) u_small (
    .clk(clk), .rst(rst), .start(s_start),
    .act_addr(s_act_addr), .act_data(8'sd1),
    .wt_addr(s_wt_addr), .wt_data(8'sd1),
    .bias_addr(s_bias_addr), .bias_data(8'sd0),
    .store(s_store), .out_c(s_out_c), .w_addr(s_w_addr), .value(s_value), .bias(s_bias),
    .pool(s_pool), .pool_done(s_pool_done), .busy(s_busy), .done(s_done)
  );

  // ---------------- saturation instance ----------------
  logic        t_start = 1'b0;
  logic signed [7:0] t_act = 8'sd0, t_wt = 8'sd0, t_bias_in = 8'sd0;
  logic [11:0] t_act_addr;
  logic [10:0] t_wt_addr;
  logic [3:0]  t_bias_addr, t_out_c;
  logic        t_store, t_pool, t_busy, t_done;
  logic [7:0]  t_w_addr;
  logic signed [7:0] t_value, t_bias;

  layer2_conv #(.IC(8), .OC(1), .SHIFT(0)) u_sat (
    .clk(clk), .rst(rst), .start(t_start),
    .act_addr(t_act_addr), .act_data(t_act),
    .wt_addr(t_wt_addr), .wt_data(t_wt),
    .bias_addr(t_bias_addr), .bias_data(t_bias_in),
    .store(t_store), .out_c(t_out_c), .w_addr(t_w_addr), .value(t_value), .bias(t_bias),
    .pool(t_pool), .pool_done(1'b0), .busy(t_busy), .done(t_done)
  );

  // ---------------- main instance ----------------
  logic        m_start = 1'b0, m_pool_done = 1'b0;
  logic [11:0] m_act_addr;
  logic [10:0] m_wt_addr;
  logic [3:0]  m_bias_addr, m_out_c;
  logic        m_store, m_pool, m_busy, m_done;
  logic [7:0]  m_w_addr;
  logic signed [7:0] m_value, m_bias;
  logic signed [7:0] m_act_data = 8'sd0, m_wt_data = 8'sd0, m_bias_data = 8'sd0;

  layer2_conv #(.IC(M_IC), .OC(M_OC), .SHIFT(M_SHIFT)) u_main (
    .clk(clk), .rst(rst), .start(m_start),
    .act_addr(m_act_addr), .act_data(m_act_data),
    .wt_addr(m_wt_addr), .wt_data(m_wt_data),
    .bias_addr(m_bias_addr), .bias_data(m_bias_data),
    .store(m_store), .out_c(m_out_c), .w_addr(m_w_addr), .value(m_value), .bias(m_bias),
    .pool(m_pool), .pool_done(m_pool_done), .busy(m_busy), .done(m_done)
  );

  // Reference data held as images and kernels; the ROMs below decode flat addresses
  logic signed [7:0] act_img [M_IC][16][16];
  logic signed [7:0] kern    [M_OC][M_IC][3][3];
  logic signed [7:0] bias_rom[16];

  always @(posedge clk) begin : main_rom
    int ai, ar, ac, wo, wi, wk;
    ai = int'(m_act_addr) / 256;
    ar = (int'(m_act_addr) / 16) % 16;
    ac = int'(m_act_addr) % 16;
    wo = int'(m_wt_addr) / (M_IC * 9);
    wi = (int'(m_wt_addr) % (M_IC * 9)) / 9;
    wk = int'(m_wt_addr) % 9;
    m_act_data  <= (ai < M_IC) ? act_img[ai][ar][ac] : 8'sd0;
    m_wt_data   <= (wo < M_OC) ? kern[wo][wi][wk / 3][wk % 3] : 8'sd0;
    m_bias_data <= bias_rom[m_bias_addr];
  end

  function automatic int golden(input int oc, input int r, input int c);
    int sum = 0;
    for (int i = 0; i < M_IC; i++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          sum += int'(act_img[i][r + ky][c + kx]) * int'(kern[oc][i][ky][kx]);
    sum = sum >>> M_SHIFT;
    if (sum > 127)  return 127;
    if (sum < -128) return -128;
    return sum;
  endfunction

  typedef struct { int oc; int waddr; int value; int bias; } exp_t;
  exp_t exp_q[$];

  task automatic build_expected();
    exp_q.delete();
    for (int oc = 0; oc < M_OC; oc++)
      for (int r = 0; r < 14; r++)
        for (int c = 0; c < 14; c++)
          exp_q.push_back('{oc, r * 14 + c, golden(oc, r, c), int'(bias_rom[oc])});
  endtask

  // ---------------- monitors ----------------
  bit overlap = 0;
  bit main_check_en = 0;
  int m_store_cnt = 0, m_done_cnt = 0;
  int s_cnt = 0, s_last_cyc = 0, s_done_cnt = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if ((m_store && m_pool) || (s_store && s_pool) || (t_store && t_pool)) overlap = 1;
    if (m_done) m_done_cnt++;
    if (s_done) s_done_cnt++;
    if (m_store) begin
      m_store_cnt++;
      if (main_check_en) begin
        if (exp_q.size() == 0) begin
          check("main extra store", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("main out_c",  longint'(m_out_c),  longint'(e.oc));
          check("main w_addr", longint'(m_w_addr), longint'(e.waddr));
          check("main value",  longint'(m_value),  longint'(e.value));
          check("main bias",   longint'(m_bias),   longint'(e.bias));
        end
      end
    end
    if (s_store) begin
      check("small value", longint'(s_value), 9);
      check("small w_addr order", longint'(s_w_addr), longint'(s_cnt));
      if (s_cnt > 0) check("small store spacing", longint'(cyc - s_last_cyc), 12);
      s_last_cyc = cyc;
      s_cnt++;
    end
  end

  // ---------------- saturation table ----------------
  typedef struct {
    logic signed [7:0] act;
    logic signed [7:0] wt;
    logic signed [7:0] bias_in;
    int                exp_value;
  } sat_vec_t;
  sat_vec_t sat_tbl[7];

  task automatic set_vec(input int i, input int a, input int w, input int b, input int e);
    sat_tbl[i].act       = 8'(a);
    sat_tbl[i].wt        = 8'(w);
    sat_tbl[i].bias_in   = 8'(b);
    sat_tbl[i].exp_value = e;
  endtask

  task automatic pulse_m_start();
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
  endtask

  task automatic check_main_reset_values(input string tag);
    check({tag, " store"},     longint'(m_store), 0);
    check({tag, " pool"},      longint'(m_pool), 0);
    check({tag, " busy"},      longint'(m_busy), 0);
    check({tag, " done"},      longint'(m_done), 0);
    check({tag, " out_c"},     longint'(m_out_c), 0);
    check({tag, " w_addr"},    longint'(m_w_addr), 0);
    check({tag, " value"},     longint'(m_value), 0);
    check({tag, " bias"},      longint'(m_bias), 0);
    check({tag, " bias_addr"}, longint'(m_bias_addr), 0);
    check({tag, " act_addr"},  longint'(m_act_addr), 0);
    check({tag, " wt_addr"},   longint'(m_wt_addr), 0);
  endtask

  task automatic wait_main_pool(input string tag);
    int t = 0;
    while (!m_pool && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " reached pool"}, longint'(m_pool), 1);
  endtask

  initial begin
    int t, snap, pool_drop, early_done;

    set_vec(0,  127,  127, 3,  127);
    set_vec(1,  127, -128, -7, -128);
    set_vec(2, -128, -128, 0,  127);
    set_vec(3,    1,    1, 5,  72);
    set_vec(4,   -1,    1, -1, -72);
    set_vec(5,    2,   -3, 9,  -128);
    set_vec(6,    0,   99, 100, 0);

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check_main_reset_values("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---- small instance: cadence, order, pool handshake ----
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("small busy after start", longint'(s_busy), 1);
    t = 0;
    while (!s_pool && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("small reached pool", longint'(s_pool), 1);
    check("small store count", longint'(s_cnt), 196);
    pool_drop = 0;
    early_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!s_pool) pool_drop++;
      if (s_done) early_done++;
    end
    check("small pool held low-drop count", longint'(pool_drop), 0);
    check("small done before pool_done", longint'(early_done), 0);
    s_pool_done = 1'b1;
    @(negedge clk);
    s_pool_done = 1'b0;
    check("small done after pool_done", longint'(s_done), 1);
    check("small pool dropped in FIN", longint'(s_pool), 0);
    check("small busy in FIN", longint'(s_busy), 1);
    @(negedge clk);
    check("small done one cycle", longint'(s_done), 0);
    check("small busy after FIN", longint'(s_busy), 0);
    repeat (5) @(negedge clk);
    check("small done pulse count", longint'(s_done_cnt), 1);

    // ---- saturation table, first four pixels of each fill ----
    for (int v = 0; v < 7; v++) begin
      rst = 1'b0;
      t_act = sat_tbl[v].act;
      t_wt = sat_tbl[v].wt;
      t_bias_in = sat_tbl[v].bias_in;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      t_start = 1'b1;
      @(negedge clk);
      t_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        t = 0;
        @(negedge clk);
        while (!t_store && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("sat store seen", longint'(t_store), 1);
        check("sat value", longint'(t_value), longint'(sat_tbl[v].exp_value));
        check("sat w_addr", longint'(t_w_addr), longint'(k));
        check("sat bias", longint'(t_bias), longint'(sat_tbl[v].bias_in));
        check("sat out_c", longint'(t_out_c), 0);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ---- main instance: random data vs. model ----
    for (int i = 0; i < M_IC; i++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          act_img[i][r][c] = 8'($urandom);
    for (int o = 0; o < M_OC; o++)
      for (int i = 0; i < M_IC; i++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            kern[o][i][ky][kx] = 8'($urandom);
    for (int b = 0; b < 16; b++) bias_rom[b] = 8'($urandom);
    build_expected();
    main_check_en = 1;
    m_store_cnt = 0;
    m_done_cnt = 0;
    pulse_m_start();
    wait_main_pool("random run");
    repeat (3) @(negedge clk);
    m_pool_done = 1'b1;
    @(negedge clk);
    m_pool_done = 1'b0;
    check("random run done", longint'(m_done), 1);
    repeat (3) @(negedge clk);
    check("random run store count", longint'(m_store_cnt), M_PIX);
    check("random run queue drained", longint'(exp_q.size()), 0);
    check("random run done count", longint'(m_done_cnt), 1);

    // ---- asynchronous reset in mid-MAC of oc=3 ----
    build_expected();
    m_store_cnt = 0;
    pulse_m_start();
    t = 0;
    while (!(m_store && m_out_c == 4'd3) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("reached oc3", longint'(m_out_c), 3);
    main_check_en = 0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_main_reset_values("async reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    snap = m_store_cnt;
    repeat (30) @(negedge clk);
    check("no store after reset release", longint'(m_store_cnt - snap), 0);
    check_main_reset_values("post reset");

    // ---- restart with ignored start pulses in MAC and POOL ----
    build_expected();
    main_check_en = 1;
    m_store_cnt = 0;
    m_done_cnt = 0;
    pulse_m_start();
    t = 0;
    while (!m_store && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    pulse_m_start();
    wait_main_pool("restart run");
    pulse_m_start();
    repeat (4) @(negedge clk);
    check("pool held after start in pool", longint'(m_pool), 1);
    check("busy held in pool", longint'(m_busy), 1);
    m_pool_done = 1'b1;
    @(negedge clk);
    m_pool_done = 1'b0;
    check("restart done", longint'(m_done), 1);
    repeat (30) @(negedge clk);
    check("restart store count", longint'(m_store_cnt), M_PIX);
    check("restart queue drained", longint'(exp_q.size()), 0);
    check("restart done count", longint'(m_done_cnt), 1);
    check("restart idle at end", longint'(m_busy), 0);

    check("store and pool overlap", longint'(overlap), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
